z80_pwm_timer: RTL

Multi-channel PWM generator and periodic interrupt timer on the Z80 I/O bus. It generalises the single-compare divider output into N channels with per-channel duty, a programmable prescaler and period, shadowed glitch-free updates, and a latched, acknowledgeable interrupt. It sits in the CPLD glue logic beside the LCD and keyboard decode, clocked from the 24 MHz oscillator.

---
 rtl/z80_pwm_timer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/z80_pwm_timer.sv
// Multi-channel PWM generator and periodic interrupt timer on the Z80 I/O bus.
// Shadowed duty/period registers reload on counter wrap; /INT is latched until acked.
module z80_pwm_timer #(
  parameter int unsigned CHANNELS = 4,
  parameter logic [3:0]  BASE     = 4'h0
) (
  input  logic                in_clock,
  input  logic                rst,
  input  logic [7:0]          adr,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic                data_oe,
  input  logic                iorq,
  input  logic                rd,
  input  logic                wr,
  input  logic                m1,
  output logic [CHANNELS-1:0] pwm,
  output logic                intrpt
);

  logic [1:0]          iorq_sync_q, wr_sync_q, m1_sync_q;
  logic                bus_w_prev_q;
  logic [7:0]          duty_sh_q  [CHANNELS];
  logic [7:0]          duty_sh_d  [CHANNELS];
  logic [7:0]          duty_act_q [CHANNELS];
  logic [7:0]          duty_act_d [CHANNELS];
  logic [7:0]          period_sh_q, period_sh_d;
  logic [7:0]          period_act_q, period_act_d;
  logic [7:0]          prescale_q, prescale_d;
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] pol_q, pol_d;
  logic                run_q, run_d;
  logic                irq_en_q, irq_en_d;
  logic                irq_flag_q, irq_flag_d;
  logic [7:0]          pcnt_q, pcnt_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                intrpt_q;

  logic       sel, bus_w, wstb, inta, tick, wrap, load, irq_clr;
  logic [7:0] rdata;

  assign sel   = (adr[7:4] == BASE);
  assign bus_w = iorq_sync_q[1] | wr_sync_q[1];
  assign wstb  = bus_w_prev_q & ~bus_w & sel;
  assign inta  = ~m1_sync_q[1] & ~iorq_sync_q[1];

  assign tick = run_q & (pcnt_q == prescale_q);
  assign wrap = tick & (cnt_q == period_act_q);
  // Loading from the _d shadows lets a write landing on the wrap cycle take effect.
  assign load = wrap | ~run_q;

  always_comb begin
    duty_sh_d   = duty_sh_q;
    period_sh_d = period_sh_q;
    prescale_d  = prescale_q;
    en_d        = en_q;
    pol_d       = pol_q;
    run_d       = run_q;
    irq_en_d    = irq_en_q;
    irq_clr     = inta;
    if (wstb) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (adr[3:0] == 4'(i)) duty_sh_d[i] = data_in;
      end
      case (adr[3:0])
        4'h8: en_d        = data_in[CHANNELS-1:0];
        4'h9: prescale_d  = data_in;
        4'hA: period_sh_d = data_in;
        4'hB: irq_clr     = inta | data_in[0];
        4'hD: pol_d       = data_in[CHANNELS-1:0];
        4'hE: begin
          run_d    = data_in[0];
          irq_en_d = data_in[1];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    duty_act_d   = duty_act_q;
    period_act_d = period_act_q;
    pcnt_d       = pcnt_q;
    cnt_d        = cnt_q;
    if (load) begin
      duty_act_d   = duty_sh_d;
      period_act_d = period_sh_d;
    end
    if (!run_q) begin
      pcnt_d = '0;
      cnt_d  = '0;
    end else if (tick) begin
      pcnt_d = '0;
      cnt_d  = wrap ? '0 : cnt_q + 8'd1;
    end else begin
      pcnt_d = pcnt_q + 8'd1;
    end
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = en_q[i] & (pol_q[i] ^ (cnt_q < duty_act_q[i]));
    end
    irq_flag_d = (wrap & irq_en_q) | (irq_flag_q & ~irq_clr);
  end

  always_ff @(posedge in_clock or posedge rst) begin
    if (rst) begin
      iorq_sync_q  <= '1;
      wr_sync_q    <= '1;
      m1_sync_q    <= '1;
      bus_w_prev_q <= 1'b1;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
      period_sh_q  <= '1;
      period_act_q <= '1;
      prescale_q   <= '0;
      en_q         <= '0;
      pol_q        <= '0;
      run_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_flag_q   <= 1'b0;
      pcnt_q       <= '0;
      cnt_q        <= '0;
      pwm_q        <= '0;
      intrpt_q     <= 1'b1;
    end else begin
      iorq_sync_q  <= {iorq_sync_q[0], iorq};
      wr_sync_q    <= {wr_sync_q[0], wr};
      m1_sync_q    <= {m1_sync_q[0], m1};
      bus_w_prev_q <= bus_w;
      duty_sh_q    <= duty_sh_d;
      duty_act_q   <= duty_act_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      prescale_q   <= prescale_d;
      en_q         <= en_d;
      pol_q        <= pol_d;
      run_q        <= run_d;
      irq_en_q     <= irq_en_d;
      irq_flag_q   <= irq_flag_d;
      pcnt_q       <= pcnt_d;
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
      intrpt_q     <= ~irq_flag_q;
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (adr[3:0] == 4'(i)) rdata = duty_sh_q[i];
    end
    case (adr[3:0])
      4'h8: begin
        for (int unsigned i = 0; i < CHANNELS; i++) rdata[i] = en_q[i];
      end
      4'h9: rdata = prescale_q;
      4'hA: rdata = period_sh_q;
      4'hB: rdata = {7'b0, irq_flag_q};
      4'hC: rdata = cnt_q;
      4'hD: begin
        for (int unsigned i = 0; i < CHANNELS; i++) rdata[i] = pol_q[i];
      end
      4'hE: rdata = {6'b0, irq_en_q, run_q};
      default: ;
    endcase
  end

  assign data_oe  = ~iorq & ~rd & sel;
  assign data_out = data_oe ? rdata : '0;
  assign pwm      = pwm_q;
  assign intrpt   = intrpt_q;

endmodule
